ap_cam_ctrl: RTL and testbench
==============================

AP_CAM_CTRL -- requirements
Module: ap_cam_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, CAM word width; DATA_DEPTH, default 16, CAM row count; ADDR_WIDTH_CAM, default 8, CAM address width.
REQ-002 Mode parameters SHALL be: RowxRow, default 3'd1; ColxCol, default 3'd2; COPY_B, default 3'd3; COPY_R, default 3'd4; COPY_A, default 3'd5.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_In  in  1  asynchronous active-low reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_op  in  3  operation: 0 LOAD, 1 STORE, 2 COPYB, 3 COPYR, 4 SEARCH; other codes are NOP.
- cmd_key  in  DATA_WIDTH  search word.
- cmd_mask  in  DATA_WIDTH  search column enable, 1 = compared.
- wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_WIDTH  load row stream.
- rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_WIDTH  store row stream.
- match_valid / match_vec  out / out  1 / DATA_DEPTH  search result, one-cycle pulse.
- done  out  1  one-cycle pulse when a command retires.
- cam_mode  out  3  CAM input_mode.
- cam_rst_In  out  1  CAM write inhibit, 1 = hold.
- cam_addr_input_rbr / cam_addr_output_rbr  out  ADDR_WIDTH_CAM each  CAM row addresses.
- cam_input_row  out  DATA_WIDTH  CAM write data.
- cam_key / cam_mask  out  1 / DATA_WIDTH  CAM compare controls.
- cam_Q_out_row  in  DATA_WIDTH  CAM row readout.
- cam_tag_row  in  DATA_DEPTH  CAM combinational match tags.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, ST_ADDR, ST_WAIT1, ST_WAIT2, ST_OUT, COPY, SRCH1, SRCH0 and DONE.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-007 Acceptance SHALL transition as follows: LOAD -> LOAD; STORE -> ST_ADDR; COPYB or COPYR -> COPY; SEARCH -> SRCH1; NOP -> DONE. The row counter SHALL clear to 0 and cmd_key / cmd_mask SHALL be latched.
REQ-008 In LOAD, wr_ready SHALL be 1. On each wr_valid & wr_ready the block SHALL drive cam_mode=RowxRow, cam_rst_In=0, cam_addr_input_rbr=row and cam_input_row=wr_data (combinationally, same cycle), then increment row. In all other cycles cam_rst_In SHALL be 1.
REQ-009 LOAD SHALL exit to DONE after the beat with row = DATA_DEPTH-1; wr_valid gaps SHALL stall without a write.
REQ-010 In ST_ADDR through ST_OUT, cam_mode SHALL be RowxRow and cam_addr_output_rbr SHALL be row. In all other states cam_addr_output_rbr SHALL be DATA_DEPTH+3 (readout disabled).
REQ-011 Store path: ST_ADDR -> ST_WAIT1 -> ST_WAIT2 -> ST_OUT. In ST_OUT, rd_valid=1 and rd_data=cam_Q_out_row; on rd_ready the row SHALL increment and return to ST_ADDR, or go to DONE after row DATA_DEPTH-1.
REQ-012 rd_valid SHALL be 0 outside ST_OUT; rd_data SHALL stay stable while rd_valid & !rd_ready.
REQ-013 COPY SHALL last exactly one cycle with cam_mode=COPY_B (COPYB) or COPY_R (COPYR) and cam_rst_In=0, then go to DONE.
REQ-014 In SRCH1 the block SHALL drive cam_key=1 and cam_mask=key & mask, and register tmp=cam_tag_row.
REQ-015 In SRCH0 the block SHALL drive cam_key=0 and cam_mask=~key & mask; match_vec SHALL register tmp & cam_tag_row, with match_valid=1 the next cycle (DONE state).
REQ-016 Search latency SHALL be exactly 3 cycles from acceptance to the match_valid pulse; mask=0 SHALL yield all-ones match_vec.
REQ-017 In IDLE, DONE and search states, cam_mode SHALL be 0 (CAM holds).
REQ-018 DONE SHALL last one cycle: done=1, then IDLE. cmd_valid during a busy state SHALL be ignored (not queued).
REQ-019 match_vec SHALL hold its last value until the next search completes.

Reset
REQ-020 Asserting rst_In low at any time SHALL force IDLE and row=0, and clear tmp and match_vec.
REQ-021 Under reset, all handshake and pulse outputs (cmd_ready, wr_ready, rd_valid, match_valid, done) SHALL be 0; cam_rst_In SHALL be 1; cam_mode SHALL be 0; cam_addr_output_rbr SHALL be DATA_DEPTH+3.
REQ-022 Reset mid-LOAD or mid-STORE SHALL abandon the operation; rows already written remain in the CAM.

Structure
REQ-023 The mode codes, cmd_op encodings and state encoding SHALL live in a shared package ap_pkg.
REQ-024 The block SHALL be a single module with no sub-modules; it connects one-to-one to a cell_A-style array.

Verification
REQ-025 LOAD rows 0..15 with values 8'h10+i, wr_valid gap at row 5 -> exactly 16 write cycles, addresses 0..15 in order, done one cycle after the last beat.
REQ-026 STORE after REQ-025, rd_ready low for 3 cycles at row 2 -> rd_data 8'h10..8'h1F in order, rd_data stable while stalled.
REQ-027 SEARCH key=8'h13 mask=8'hFF -> match_vec=16'h0008 exactly 3 cycles after acceptance.
REQ-028 SEARCH key=8'h10 mask=8'hF0 -> match_vec=16'hFFFF; mask=8'h00 -> 16'hFFFF.
REQ-029 COPYB -> one cycle with cam_mode=3, cam_rst_In=0, then done; cmd_valid held high while busy is not accepted.
REQ-030 rst_In low during LOAD row 7 -> IDLE immediately, cam_rst_In=1, next LOAD restarts at row 0.

Source files
------------

// File: rtl/ap_pkg.sv
// rtl/ap_pkg.sv - shared mode codes, command opcodes and FSM state encoding for ap_cam_ctrl
package ap_pkg;

  localparam logic [2:0] MODE_HOLD    = 3'd0;
  localparam logic [2:0] MODE_ROWXROW = 3'd1;
  localparam logic [2:0] MODE_COLXCOL = 3'd2;
  localparam logic [2:0] MODE_COPY_B  = 3'd3;
  localparam logic [2:0] MODE_COPY_R  = 3'd4;
  localparam logic [2:0] MODE_COPY_A  = 3'd5;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_STORE  = 3'd1;
  localparam logic [2:0] OP_COPYB  = 3'd2;
  localparam logic [2:0] OP_COPYR  = 3'd3;
  localparam logic [2:0] OP_SEARCH = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_ST_ADDR  = 4'd2,
    S_ST_WAIT1 = 4'd3,
    S_ST_WAIT2 = 4'd4,
    S_ST_OUT   = 4'd5,
    S_COPY     = 4'd6,
    S_SRCH1    = 4'd7,
    S_SRCH0    = 4'd8,
    S_DONE     = 4'd9
  } state_t;

endpackage

// File: rtl/ap_cam_ctrl.sv
// rtl/ap_cam_ctrl.sv - command sequencer driving a cell_A-style CAM array
// Handles row load/store streams, array copies and two-phase masked search.
module ap_cam_ctrl
  import ap_pkg::*;
#(
  parameter int         DATA_WIDTH     = 8,
  parameter int         DATA_DEPTH     = 16,
  parameter int         ADDR_WIDTH_CAM = 8,
  parameter logic [2:0] RowxRow        = MODE_ROWXROW,
  parameter logic [2:0] ColxCol        = MODE_COLXCOL,
  parameter logic [2:0] COPY_B         = MODE_COPY_B,
  parameter logic [2:0] COPY_R         = MODE_COPY_R,
  parameter logic [2:0] COPY_A         = MODE_COPY_A
) (
  input  logic                      clk,
  input  logic                      rst_In,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic [DATA_WIDTH-1:0]     cmd_key,
  input  logic [DATA_WIDTH-1:0]     cmd_mask,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      match_valid,
  output logic [DATA_DEPTH-1:0]     match_vec,
  output logic                      done,
  output logic [2:0]                cam_mode,
  output logic                      cam_rst_In,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_input_rbr,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_output_rbr,
  output logic [DATA_WIDTH-1:0]     cam_input_row,
  output logic                      cam_key,
  output logic [DATA_WIDTH-1:0]     cam_mask,
  input  logic [DATA_WIDTH-1:0]     cam_Q_out_row,
  input  logic [DATA_DEPTH-1:0]     cam_tag_row
);

  localparam logic [ADDR_WIDTH_CAM-1:0] LAST_ROW = ADDR_WIDTH_CAM'(DATA_DEPTH - 1);
  // An out-of-range row address disables the array readout.
  localparam logic [ADDR_WIDTH_CAM-1:0] ADDR_OFF = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
  localparam logic [ADDR_WIDTH_CAM-1:0] ROW_ONE  = ADDR_WIDTH_CAM'(1);

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH_CAM-1:0] row_q, row_d;
  logic [DATA_WIDTH-1:0]     key_q, key_d;
  logic [DATA_WIDTH-1:0]     mask_q, mask_d;
  logic [2:0]                op_q, op_d;
  logic [DATA_DEPTH-1:0]     tmp_q, tmp_d;
  logic [DATA_DEPTH-1:0]     match_vec_q, match_vec_d;
  logic                      match_valid_q, match_valid_d;

  logic unused_modes;
  assign unused_modes = ^{ColxCol, COPY_A};

  always_ff @(posedge clk or negedge rst_In) begin
    if (!rst_In) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      key_q         <= '0;
      mask_q        <= '0;
      op_q          <= '0;
      tmp_q         <= '0;
      match_vec_q   <= '0;
      match_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      key_q         <= key_d;
      mask_q        <= mask_d;
      op_q          <= op_d;
      tmp_q         <= tmp_d;
      match_vec_q   <= match_vec_d;
      match_valid_q <= match_valid_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    row_d               = row_q;
    key_d               = key_q;
    mask_d              = mask_q;
    op_d                = op_q;
    tmp_d               = tmp_q;
    match_vec_d         = match_vec_q;
    match_valid_d       = 1'b0;
    cmd_ready           = 1'b0;
    wr_ready            = 1'b0;
    rd_valid            = 1'b0;
    done                = 1'b0;
    cam_mode            = MODE_HOLD;
    cam_rst_In          = 1'b1;
    cam_addr_output_rbr = ADDR_OFF;
    cam_key             = 1'b0;
    cam_mask            = '0;

    case (state_q)
      S_IDLE: begin
        // Gated so the handshake reads 0 while reset is held.
        cmd_ready = rst_In;
        if (cmd_valid) begin
          row_d  = '0;
          key_d  = cmd_key;
          mask_d = cmd_mask;
          op_d   = cmd_op;
          case (cmd_op)
            OP_LOAD:            state_d = S_LOAD;
            OP_STORE:           state_d = S_ST_ADDR;
            OP_COPYB, OP_COPYR: state_d = S_COPY;
            OP_SEARCH:          state_d = S_SRCH1;
            default:            state_d = S_DONE;
          endcase
        end
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        cam_mode = RowxRow;
        if (wr_valid) begin
          cam_rst_In = 1'b0;
          row_d      = row_q + ROW_ONE;
          if (row_q == LAST_ROW) state_d = S_DONE;
        end
      end
      S_ST_ADDR: begin
        cam_mode            = RowxRow;
        cam_addr_output_rbr = row_q;
        state_d             = S_ST_WAIT1;
      end
      S_ST_WAIT1: begin
        cam_mode            = RowxRow;
        cam_addr_output_rbr = row_q;
        state_d             = S_ST_WAIT2;
      end
      S_ST_WAIT2: begin
        cam_mode            = RowxRow;
        cam_addr_output_rbr = row_q;
        state_d             = S_ST_OUT;
      end
      S_ST_OUT: begin
        cam_mode            = RowxRow;
        cam_addr_output_rbr = row_q;
        rd_valid            = 1'b1;
        if (rd_ready) begin
          row_d   = row_q + ROW_ONE;
          state_d = (row_q == LAST_ROW) ? S_DONE : S_ST_ADDR;
        end
      end
      S_COPY: begin
        cam_mode   = (op_q == OP_COPYB) ? COPY_B : COPY_R;
        cam_rst_In = 1'b0;
        state_d    = S_DONE;
      end
      // Two compare passes: columns where the key is 1, then where it is 0.
      S_SRCH1: begin
        cam_key  = 1'b1;
        cam_mask = key_q & mask_q;
        tmp_d    = cam_tag_row;
        state_d  = S_SRCH0;
      end
      S_SRCH0: begin
        cam_key       = 1'b0;
        cam_mask      = ~key_q & mask_q;
        match_vec_d   = tmp_q & cam_tag_row;
        match_valid_d = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_data            = cam_Q_out_row;
  assign cam_input_row      = wr_data;
  assign cam_addr_input_rbr = row_q;
  assign match_vec          = match_vec_q;
  assign match_valid        = match_valid_q;

endmodule

// File: tb/tb_ap_cam_ctrl.sv
// tb/tb_ap_cam_ctrl.sv - scoreboard bench for ap_cam_ctrl with a behavioural CAM array
module tb_ap_cam_ctrl;

  logic        clk = 1'b0;
  logic        rst_In;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_key, cmd_mask;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        match_valid;
  logic [15:0] match_vec;
  logic        done;
  logic [2:0]  cam_mode;
  logic        cam_rst_In;
  logic [7:0]  cam_addr_input_rbr, cam_addr_output_rbr;
  logic [7:0]  cam_input_row;
  logic        cam_key;
  logic [7:0]  cam_mask;
  logic [7:0]  cam_Q_out_row;
  logic [15:0] cam_tag_row;

  always #5 clk = ~clk;

  ap_cam_ctrl dut (
    .clk(clk), .rst_In(rst_In),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_mask(cmd_mask),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .match_valid(match_valid), .match_vec(match_vec), .done(done),
    .cam_mode(cam_mode), .cam_rst_In(cam_rst_In),
    .cam_addr_input_rbr(cam_addr_input_rbr), .cam_addr_output_rbr(cam_addr_output_rbr),
    .cam_input_row(cam_input_row), .cam_key(cam_key), .cam_mask(cam_mask),
    .cam_Q_out_row(cam_Q_out_row), .cam_tag_row(cam_tag_row)
  );

  // Behavioural array: registered row readout, combinational tags.
  logic [7:0] mem [16];
  initial for (int r = 0; r < 16; r++) mem[r] = 8'h00;

  always @(posedge clk) begin
    if (!cam_rst_In && cam_mode == 3'd1 && cam_addr_input_rbr < 8'd16)
      mem[cam_addr_input_rbr[3:0]] <= cam_input_row;
    cam_Q_out_row <= (cam_addr_output_rbr < 8'd16) ? mem[cam_addr_output_rbr[3:0]] : 8'h00;
  end

  always_comb begin
    cam_tag_row = '0;
    for (int r = 0; r < 16; r++)
      cam_tag_row[r] = &(~cam_mask | (cam_key ? mem[r] : ~mem[r]));
  end

  int total = 0, bad = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] m_q[$];
  int wr_cnt, rd_cnt, copy_cnt;
  bit done_seen, mv_seen, prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mon();
    if (!cam_rst_In && cam_mode == 3'd1) begin
      wr_cnt++;
      if (wr_q.size() == 0) chk("wr_extra", 1, 0);
      else chk("wr", {cam_addr_input_rbr, cam_input_row}, wr_q.pop_front());
    end
    if (!cam_rst_In && cam_mode == 3'd3) copy_cnt++;
    if (rd_valid && prev_stall) chk("rd_stable", rd_data, prev_data);
    if (rd_valid && rd_ready) begin
      rd_cnt++;
      if (rd_q.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd", rd_data, rd_q.pop_front());
    end
    prev_stall = rd_valid && !rd_ready;
    prev_data  = rd_data;
    if (match_valid) begin
      mv_seen = 1;
      if (m_q.size() == 0) chk("match_extra", 1, 0);
      else chk("match", match_vec, m_q.pop_front());
    end
    if (done) done_seen = 1;
  endtask

  task automatic cyc();
    #1 mon();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 50) begin cyc(); n++; end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] k, input logic [7:0] m);
    wait_idle();
    chk("issue_rdy", cmd_ready, 1);
    cmd_op = op; cmd_key = k; cmd_mask = m; cmd_valid = 1;
    cyc();
    cmd_valid = 0;
  endtask

  task automatic load_rows(input logic [7:0] base, input int gap_row);
    issue(3'd0, 8'h00, 8'h00);
    wr_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == gap_row) begin wr_valid = 0; cyc(); end
      wr_q.push_back({8'(i), base + 8'(i)});
      wr_valid = 1; wr_data = base + 8'(i);
      chk("wr_rdy", wr_ready, 1);
      cyc();
    end
    wr_valid = 0;
    chk("load_done", done, 1);
    chk("wr_cnt", wr_cnt, 16);
  endtask

  task automatic srch(input logic [7:0] k, input logic [7:0] m, input logic [15:0] exp);
    int lat = 0;
    issue(3'd4, k, m);
    m_q.push_back(exp);
    mv_seen = 0;
    while (!mv_seen && lat < 20) begin cyc(); lat++; end
    chk("srch_lat", lat, 3);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n, stall;
    rst_In = 0; cmd_valid = 0; cmd_op = 0; cmd_key = 0; cmd_mask = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    prev_stall = 0; prev_data = 0; wr_cnt = 0; rd_cnt = 0; copy_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_match_valid", match_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_cam_rst", cam_rst_In, 1);
    chk("rst_cam_mode", cam_mode, 0);
    chk("rst_addr_out", cam_addr_output_rbr, 8'd19);
    chk("rst_match_vec", match_vec, 0);
    @(negedge clk);
    rst_In = 1;
    cyc();

    load_rows(8'h10, 5);
    wait_idle();

    issue(3'd1, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) rd_q.push_back(8'h10 + 8'(i));
    rd_cnt = 0; done_seen = 0; n = 0; stall = 0;
    while (!done_seen && n < 300) begin
      if (rd_valid && rd_cnt == 2 && stall < 3) begin rd_ready = 0; stall++; end
      else rd_ready = 1;
      cyc(); n++;
    end
    rd_ready = 0;
    chk("st_done", done_seen, 1);
    chk("rd_cnt", rd_cnt, 16);
    chk("st_stalls", stall, 3);
    wait_idle();

    srch(8'h13, 8'hFF, 16'h0008);
    srch(8'h1A, 8'h0F, 16'h0400);
    srch(8'h10, 8'hF0, 16'hFFFF);
    srch(8'h10, 8'h00, 16'hFFFF);
    srch(8'h13, 8'hFF, 16'h0008);
    repeat (3) cyc();
    chk("mv_hold", match_vec, 16'h0008);

    wait_idle();
    copy_cnt = 0;
    cmd_op = 3'd2; cmd_valid = 1;
    cyc();
    chk("cp_mode", cam_mode, 3'd3);
    chk("cp_we", cam_rst_In, 0);
    chk("cp_addr_off", cam_addr_output_rbr, 8'd19);
    cyc();
    chk("cp_done", done, 1);
    chk("cp_busy_rdy", cmd_ready, 0);
    cmd_valid = 0;
    cyc();
    chk("cp_idle_done", done, 0);
    chk("cp_cnt", copy_cnt, 1);
    chk("cp_mode_idle", cam_mode, 0);

    issue(3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 7; i++) begin
      wr_q.push_back({8'(i), 8'h30 + 8'(i)});
      wr_valid = 1; wr_data = 8'h30 + 8'(i);
      cyc();
    end
    wr_data = 8'h37;
    rst_In = 0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_cam_rst", cam_rst_In, 1);
    chk("mid_rst_mode", cam_mode, 0);
    cyc();
    wr_valid = 0;
    rst_In = 1;
    cyc();
    load_rows(8'hA0, -1);
    wait_idle();

    chk("q_empty", wr_q.size() + rd_q.size() + m_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
